// File: rtl/ps2_key_pkg.sv
// Shared scan codes, prefix-FSM encoding and movement-code constants for the PS/2 key decoder.
package ps2_key_pkg;

    localparam logic [7:0] ScExt   = 8'hE0;
    localparam logic [7:0] ScBreak = 8'hF0;
    localparam logic [7:0] ScUp    = 8'h75;
    localparam logic [7:0] ScDown  = 8'h72;
    localparam logic [7:0] ScLeft  = 8'h6B;
    localparam logic [7:0] ScRight = 8'h74;
    localparam logic [7:0] ScSpace = 8'h29;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StExt      = 2'd1;
    localparam logic [1:0] StBreak    = 2'd2;
    localparam logic [1:0] StExtBreak = 2'd3;

    localparam logic [2:0] KeysSpace = 3'b000;
    localparam logic [2:0] KeysUp    = 3'b110;
    localparam logic [2:0] KeysDown  = 3'b001;
    localparam logic [2:0] KeysLeft  = 3'b011;
    localparam logic [2:0] KeysRight = 3'b101;
    localparam logic [2:0] KeysNone  = 3'b111;

    // One-hot key mask in {space, right, left, down, up} order; E0 29 is not space.
    function automatic logic [4:0] decode_key(input logic [7:0] code, input logic ext);
        logic [4:0] hit;
        hit = 5'b00000;
        case (code)
            ScUp:    hit = 5'b00001;
            ScDown:  hit = 5'b00010;
            ScLeft:  hit = 5'b00100;
            ScRight: hit = 5'b01000;
            ScSpace: hit = ext ? 5'b00000 : 5'b10000;
            default: hit = 5'b00000;
        endcase
        return hit;
    endfunction

    function automatic logic [2:0] encode_keys(input logic [4:0] held);
        logic [2:0] code;
        if (held[4])      code = KeysSpace;
        else if (held[0]) code = KeysUp;
        else if (held[1]) code = KeysDown;
        else if (held[2]) code = KeysLeft;
        else if (held[3]) code = KeysRight;
        else              code = KeysNone;
        return code;
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle counter for the scan-code prefix states; flags expiry after TIMEOUT_CYCLES-1 counted cycles.
module ps2_prefix_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q >= CntLast);

    // Saturates at the last count so a held-off clear can never wrap it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run && (cnt_q < CntLast)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: E0/F0 prefix FSM, held movement flags and priority-encoded keys.
// Optional one-cycle make pulses on press_evt when PS2_KEY_DECODER_PRESS_EVT_EN is defined.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_valid,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_space,
    output logic [2:0] keys,
    output logic       user_in,
    output logic [4:0] press_evt
);

    logic [1:0] state_q, state_d;
    logic [4:0] held_q, held_d;
    logic [2:0] keys_q, keys_d;
    logic       user_in_q, user_in_d;
    logic [4:0] hit;
    logic       is_ext, is_brk;
    logic       timer_clr, timer_run, timer_expired;

    assign is_ext    = (state_q == StExt) || (state_q == StExtBreak);
    assign is_brk    = (state_q == StBreak) || (state_q == StExtBreak);
    assign hit       = decode_key(ps2_byte, is_ext);
    assign timer_run = (state_q != StIdle);
    assign timer_clr = ps2_byte_valid || timer_expired;

    ps2_prefix_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_prefix_timer (
        .clk_i   (CLOCK_50),
        .rst_i   (Reset),
        .clr     (timer_clr),
        .run     (timer_run),
        .expired (timer_expired)
    );

    // A strobe takes priority over a same-cycle timer expiry.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        if (ps2_byte_valid) begin
            if ((ps2_byte == ScExt) && (state_q != StExtBreak)) begin
                state_d = StExt;
            end else if ((ps2_byte == ScBreak) && !is_brk) begin
                state_d = is_ext ? StExtBreak : StBreak;
            end else begin
                held_d  = is_brk ? (held_q & ~hit) : (held_q | hit);
                state_d = StIdle;
            end
        end else if (timer_expired) begin
            state_d = StIdle;
        end
    end

    assign keys_d    = encode_keys(held_d);
    assign user_in_d = (keys_d != KeysNone);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q   <= StIdle;
            held_q    <= 5'b00000;
            keys_q    <= KeysNone;
            user_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            keys_q    <= keys_d;
            user_in_q <= user_in_d;
        end
    end

`ifdef PS2_KEY_DECODER_PRESS_EVT_EN
    logic [4:0] press_evt_q;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            press_evt_q <= 5'b00000;
        end else begin
            press_evt_q <= held_d & ~held_q;
        end
    end

    assign press_evt = press_evt_q;
`else
    assign press_evt = 5'b00000;
`endif

    assign key_up    = held_q[0];
    assign key_down  = held_q[1];
    assign key_left  = held_q[2];
    assign key_right = held_q[3];
    assign key_space = held_q[4];
    assign keys      = keys_q;
    assign user_in   = user_in_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: max idle cycles allowed in a prefix state before returning to IDLE.
REQ-002 SHALL have port CLOCK_50, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ps2_byte, input, 8: received PS/2 scan-code byte.
REQ-005 SHALL have port ps2_byte_valid, input, 1: one-cycle strobe qualifying ps2_byte.
REQ-006 SHALL have ports key_up, key_down, key_left, key_right, key_space, each output, 1: held-level flags.
REQ-007 SHALL have port keys, output, 3: active-low movement code for the Animation stage.
REQ-008 SHALL have port user_in, output, 1: high when keys is not 3'b111.
REQ-009 SHALL have port press_evt, output, 5: one-cycle make pulses, bit order {space, right, left, down, up}.

Function
REQ-010 SHALL run a prefix FSM with states IDLE, EXT, BREAK and EXT_BREAK.
REQ-011 From IDLE, a valid E0 SHALL go to EXT, and a valid F0 SHALL go to BREAK.
REQ-012 From EXT, F0 SHALL go to EXT_BREAK, and E0 SHALL stay in EXT.
REQ-013 From BREAK, E0 SHALL go to EXT.
REQ-014 Any other valid byte SHALL be decoded in the current state, then the FSM SHALL return to IDLE.
REQ-015 Codes 75/72/6B/74 SHALL map to up/down/left/right, with or without the E0 prefix.
REQ-016 Code 29 SHALL map to space only without E0; E0 29 SHALL be ignored.
REQ-017 In IDLE or EXT, a recognised code SHALL set its held flag (make).
REQ-018 In BREAK or EXT_BREAK, a recognised code SHALL clear its held flag (break).
REQ-019 Unrecognised codes SHALL change no flag, but the FSM SHALL still return to IDLE.
REQ-020 keys SHALL be priority-encoded: space 000 > up 110 > down 001 > left 011 > right 101; no key held gives 111.
REQ-021 Latency SHALL be one cycle: flags, keys, user_in and press_evt are registered and update on the edge after the final byte's strobe.
REQ-022 A prefix timer SHALL clear on every strobe and count while the FSM is not in IDLE.
REQ-023 When the timer reaches TIMEOUT_CYCLES-1 with no strobe, the FSM SHALL return to IDLE, the timer SHALL clear, and no flag SHALL change.
REQ-024 If a strobe and timer expiry occur in the same cycle, the strobe SHALL win and the byte SHALL be decoded in the current state.
REQ-025 A make for an already-held key SHALL keep its flag high (typematic repeat) and SHALL NOT pulse press_evt.
REQ-026 A break for a key that is not held SHALL be a no-op.
REQ-027 The timer SHALL saturate and never wrap; its width SHALL be $clog2(TIMEOUT_CYCLES)+1.

Reset
REQ-028 When Reset is high at a clock edge, the FSM SHALL go to IDLE and the timer to 0.
REQ-029 On the same reset, all held flags and press_evt SHALL go to 0, keys to 3'b111 and user_in to 0.
REQ-030 Reset SHALL override a same-cycle strobe, and a reset mid-prefix SHALL discard the prefix.

Configuration
REQ-031 With PS2_KEY_DECODER_PRESS_EVT_EN defined, press_evt bit n SHALL pulse high for one cycle when key n goes from not held to held.
REQ-032 Without PS2_KEY_DECODER_PRESS_EVT_EN, press_evt SHALL be constant 5'b00000 and no edge-detect registers SHALL be generated.

Structure
REQ-033 Package ps2_key_pkg SHALL hold the scan-code constants (E0, F0, 75, 72, 6B, 74, 29), the FSM state encoding and the keys code constants (000/110/001/011/101/111).
REQ-034 The timeout counter SHALL be sub-module ps2_prefix_timer, with inputs clr and run and output expired; everything else stays in the parent.

Verification
REQ-035 Bench: strobe 75 -> key_up=1, keys=110, user_in=1 one cycle later; then F0,75 -> key_up=0, keys=111.
REQ-036 Bench: E0,72 then 29 -> key_down=1, key_space=1, keys=000; then F0,29 -> keys=001.
REQ-037 Bench: E0 then no strobe for TIMEOUT_CYCLES (use 16) -> FSM in IDLE; next 6B is a make -> key_left=1.
REQ-038 Bench: E0, F0 with Reset asserted before the next byte, then 74 -> key_right=1 (prefix discarded); E0,29 -> no change.
REQ-039 Bench, macro defined: 75,75,75 -> press_evt=00001 for exactly one cycle; macro undefined -> press_evt stays 0.
REQ-040 Bench: timer at TIMEOUT_CYCLES-1 in BREAK with strobe 6B in the same cycle -> key_left cleared (break honoured).
